// File: rtl/mul_pkg.sv
// Shared definitions for the long-multiply unit and the decoder that drives it.
package mul_pkg;

  // Multiplier sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  // ALUControl encodings the decoder emits for long multiplies.
  localparam logic [3:0] ALU_UMULL = 4'b0110;
  localparam logic [3:0] ALU_SMULL = 4'b1000;

  // Width of an iteration counter that can hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_unit_cond_neg.sv
// Conditional two's-complement negation: y = en ? -x : x (wraps modulo 2^W).
module cond_neg #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = en ? ((~x) + W'(1)) : x;

endmodule

// File: rtl/mul_unit.sv
// Iterative shift-add long multiplier (UMULL/SMULL) with N/Z flag outputs.
// Signed operands are reduced to magnitudes on capture, multiplied unsigned,
// and the product is negated once at the end when the operand signs differ.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_we
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  mul_state_t r_state;
  mul_state_t w_state_next;

  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_sf;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_flag_n;
  logic             r_flag_z;
  logic             r_done;
  logic             r_flag_we;

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_acc_fix;
  logic             w_last;

  // Only signed operands with the sign bit set need negating to a magnitude.
  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign w_neg_a = is_signed & a[WIDTH-1];
  assign w_neg_b = is_signed & b[WIDTH-1];

  cond_neg #(.W(WIDTH)) u_abs_a (
    .en (w_neg_a),
    .x  (a),
    .y  (w_abs_a)
  );

  cond_neg #(.W(WIDTH)) u_abs_b (
    .en (w_neg_b),
    .x  (b),
    .y  (w_abs_b)
  );

  // Sign restoration of the full-width product.
  cond_neg #(.W(PW)) u_fix (
    .en (r_neg),
    .x  (r_acc),
    .y  (w_acc_fix)
  );

  // The WIDTH-th iteration is the one that sees the counter at WIDTH-1.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture, shift-add iterations, and result/flag registration.
  // The sign-fixed product is registered straight into lo/hi on the FIX edge,
  // so the results are already valid during the cycle done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_sf      <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_flag_n  <= 1'b0;
      r_flag_z  <= 1'b0;
      r_done    <= 1'b0;
      r_flag_we <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_flag_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_neg_a ^ w_neg_b;
            r_sf     <= set_flags;
          end
        end
        CALC: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        FIX: begin
          r_lo      <= w_acc_fix[WIDTH-1:0];
          r_hi      <= w_acc_fix[PW-1:WIDTH];
          r_flag_n  <= w_acc_fix[PW-1];
          r_flag_z  <= (w_acc_fix == '0);
          r_done    <= 1'b1;
          r_flag_we <= r_sf;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign lo      = r_lo;
  assign hi      = r_hi;
  assign flag_n  = r_flag_n;
  assign flag_z  = r_flag_z;
  assign flag_we = r_flag_we;

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative shift-add multiplier that executes the long-multiply operations (UMULL/SMULL) flagged by the instruction decoder. It sits beside the ALU in the multicycle datapath. The main FSM pulses `start` with the decoded signedness and S bit, then waits on `done` before writing RdLo/RdHi and, optionally, the N/Z flags. It is the execution end of the decoder's `is_mul` / ALUControl (0110 UMULL, 1000 SMULL) path.

## Interface
- `WIDTH`, default 32: operand width. The product is 2×WIDTH.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  launch request; sampled only in IDLE.
- `is_signed`  in  1  1 = SMULL, 0 = UMULL; captured with `start`.
- `set_flags`  in  1  instruction S bit (Instr[20]); captured with `start`.
- `a`  in  WIDTH  Rm operand; captured with `start`.
- `b`  in  WIDTH  Rs operand; captured with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: `lo`/`hi`/flags valid.
- `lo`  out  WIDTH  product bits [WIDTH-1:0] (RdLo).
- `hi`  out  WIDTH  product bits [2·WIDTH-1:WIDTH] (RdHi).
- `flag_n`  out  1  `hi[WIDTH-1]` of the final product.
- `flag_z`  out  1  1 when the whole 2·WIDTH product is zero.
- `flag_we`  out  1  equals `done & captured set_flags`. C and V are never written.

## Operation
- FSM states are IDLE, CALC, FIX, DONE.
- **IDLE**: if `start`=1, capture the operands and control bits, clear the accumulator, set iteration counter = 0, go to CALC.
  - Signed capture: store the magnitudes |a| and |b| as unsigned WIDTH-bit values (0x80000000 stays 0x80000000), plus `neg = a[MSB] ^ b[MSB]`.
  - Unsigned capture: `neg` = 0.
- **CALC**: one iteration per cycle.
  - If the multiplier LSB = 1, add the multiplicand (2·WIDTH wide, shifted) to the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; increment the counter.
  - After WIDTH iterations, go to FIX.
- **FIX**: if `neg`, the accumulator becomes its two's-complement negation modulo 2^(2·WIDTH). Go to DONE.
- **DONE**: `done`=1; register `lo`, `hi`, `flag_n`, `flag_z`; `flag_we` = captured S bit. Go to IDLE.
- `lo`/`hi`/`flag_n`/`flag_z` hold their values until the next DONE or until reset.
- `start` in CALC, FIX or DONE is ignored and is not queued.
- Arithmetic: all internal sums are 2·WIDTH bits and wrap. No overflow indication exists; the full product always fits.

## Timing
- Reset asserted (async): state = IDLE. `busy`, `done`, `flag_we`, `flag_n`, `flag_z` = 0; `lo` = `hi` = 0.
- Reset applies immediately mid-operation. The in-flight result is discarded and no `done` is produced.
- Latency: `start` sampled at edge k → CALC on edges k+1..k+WIDTH → FIX at edge k+WIDTH+1 → `done` high for exactly the cycle after edge k+WIDTH+1.
  - For WIDTH=32, `done` is high during cycle 34 after the start edge.
- `busy` rises the cycle after the start edge and falls together with `done` leaving DONE.
- If `start` is held high continuously, the next operation launches on the edge after DONE. This gives a throughput of one result per WIDTH+3 cycles.
- `done`, `flag_we` and all result outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `mul_pkg` holds:
  - the state enum (IDLE/CALC/FIX/DONE);
  - ALUControl constants `ALU_UMULL` = 4'b0110 and `ALU_SMULL` = 4'b1000, also used by the decoder;
  - the counter width `$clog2(WIDTH+1)`.
- One natural sub-module: `cond_neg` (parameterised width, `en`, `x` → `en ? -x : x`). Instances:
  - two WIDTH-bit instances for operand magnitudes;
  - one 2·WIDTH-bit instance for FIX.
- Everything else lives in `mul_unit`.

## Test plan
- **Unsigned max**: UMULL a=0xFFFFFFFF, b=0xFFFFFFFF, set_flags=1 → `hi`=0xFFFFFFFE, `lo`=0x00000001, N=1, Z=0, `flag_we`=1. `done` arrives exactly 34 cycles after the start edge.
- **Signed mixed signs**: SMULL a=0xFFFFFFFD (−3), b=5, set_flags=1 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, N=1, Z=0.
- **Signed corner**: SMULL a=b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000. With set_flags=0: `flag_we`=0 while `done`=1.
- **Zero product**: UMULL a=0, b=0x12345678, set_flags=1 → `lo`=`hi`=0, Z=1, N=0.
- **Reset mid-operation**: drive `reset`=0 at cycle 10 of CALC → `busy`=0 and `lo`=`hi`=0 immediately. No `done` pulse follows. A new `start` after release produces the correct result.
- **Start handling**: pulse `start` at cycle 5 of CALC → ignored and the result is unchanged. Hold `start` high through two operations → the second launches on the edge after the first DONE, and the two `done` pulses are 35 cycles apart.
